regfile_wb_arbiter: RTL and testbench

- Shares the single write port (wa3/we3/wd3) of the 16x32 `registerFile` between two write-back requesters: ALU result and memory load.
- Registered round-robin arbitration with a valid/ready handshake on each requester.
- Writes addressed to r15 are redirected to the PC write path, because the register file supplies r15 externally.
- Keeps a pending-write scoreboard and raises a read-hazard flag for the decode stage's ra1/ra2.

---
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port (wa3/we3/wd3) between the ALU
//   and load write-back paths. Each cycle a registered round-robin pointer
//   picks one requester, and that request is committed one cycle later.
//   Writes to PC_ADDR are steered to the PC write path instead, because the
//   register file sources that index externally. A pending-write scoreboard
//   drives the decode read-hazard flag.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   alu_valid/addr/data, ready   ALU write-back request and handshake
//   mem_valid/addr/data, ready   load write-back request and handshake
//   alloc_valid, alloc_addr      issue marks a destination register pending
//   ra1, ra2                     decode read addresses
//   hazard                       ra1 or ra2 has an outstanding write
//   wa3, we3, wd3                register-file write port
//   pc_we, pc_wd                 PC write strobe and data
//   pending                      scoreboard, bit i = write to Ri outstanding
//   unalloc_wr                   committed write to a non-pending register
//
// Round-robin pointer
//   state  | meaning
//   RR_ALU | ALU wins when both requesters are valid
//   RR_MEM | MEM wins when both requesters are valid
module regfile_wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int NREG    = 16,
  parameter int PC_ADDR = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              hazard,
  output logic [ADDR_W-1:0] wa3,
  output logic              we3,
  output logic [DATA_W-1:0] wd3,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wd,
  output logic [NREG-1:0]   pending,
  output logic              unalloc_wr
);

  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_ADDR);

  typedef enum logic {RR_ALU = 1'b0, RR_MEM = 1'b1} rr_t;

  rr_t               rr_q, rr_d;
  logic              grant_alu, grant_mem, grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_pc;
  logic [ADDR_W-1:0] commit_addr;
  logic              commit;
  logic [NREG-1:0]   pending_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_q <= RR_ALU;
    else          rr_q <= rr_d;
  end

  // Grants are gated by reset_n so no handshake is reported while in reset.
  always_comb begin
    rr_d      = rr_q;
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (reset_n) begin
      if (alu_valid && (!mem_valid || rr_q == RR_ALU)) grant_alu = 1'b1;
      else if (mem_valid)                              grant_mem = 1'b1;
    end
    if (grant_alu)      rr_d = RR_MEM;
    else if (grant_mem) rr_d = RR_ALU;
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign grant     = grant_alu | grant_mem;
  assign sel_addr  = grant_alu ? alu_addr : mem_addr;
  assign sel_data  = grant_alu ? alu_data : mem_data;
  assign sel_pc    = (sel_addr == PC_IDX);

  // commit_addr tracks the target of every commit, including PC writes,
  // since wa3 must hold its previous value across a PC redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we3         <= 1'b0;
      wa3         <= '0;
      wd3         <= '0;
      pc_we       <= 1'b0;
      pc_wd       <= '0;
      commit_addr <= '0;
    end else begin
      we3   <= grant & ~sel_pc;
      pc_we <= grant & sel_pc;
      if (grant) commit_addr <= sel_addr;
      if (grant && !sel_pc) begin
        wa3 <= sel_addr;
        wd3 <= sel_data;
      end
      if (grant && sel_pc) pc_wd <= sel_data;
    end
  end

  assign commit = we3 | pc_we;

  // Clear first, then set, so a same-edge re-allocation keeps the bit.
  always_comb begin
    pending_d = pending;
    if (commit)      pending_d[commit_addr] = 1'b0;
    if (alloc_valid) pending_d[alloc_addr]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_d;
  end

  assign unalloc_wr = commit & ~pending[commit_addr];
  assign hazard     = pending[ra1] | pending[ra2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, mem_valid, alloc_valid;
  logic [3:0]  alu_addr, mem_addr, alloc_addr, ra1, ra2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, hazard, we3, pc_we, unalloc_wr;
  logic [3:0]  wa3;
  logic [31:0] wd3, pc_wd;
  logic [15:0] pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(4), .NREG(16), .PC_ADDR(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .ra1(ra1), .ra2(ra2),
    .hazard(hazard), .wa3(wa3), .we3(we3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd),
    .pending(pending), .unalloc_wr(unalloc_wr)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    alloc_valid = 0; alloc_addr = 0; ra1 = 0; ra2 = 0;
  endtask

  task automatic do_reset;
    reset_n = 0;
    idle_inputs();
    tick();
    reset_n = 1;
  endtask

  task automatic test_reset;
    reset_n = 0;
    alu_valid = 1; alu_addr = 4; alu_data = 32'h44;
    mem_valid = 1; mem_addr = 6; mem_data = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #2;
      total++; if (we3 !== 1'b0) begin bad++; $display("FAIL rst_we3 got=%0h want=0", we3); end
      total++; if (pc_we !== 1'b0) begin bad++; $display("FAIL rst_pc_we got=%0h want=0", pc_we); end
      total++; if (pending !== 16'h0000) begin bad++; $display("FAIL rst_pending got=%0h want=0", pending); end
      total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL rst_alu_ready got=%0h want=0", alu_ready); end
      total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rst_mem_ready got=%0h want=0", mem_ready); end
      total++; if (unalloc_wr !== 1'b0) begin bad++; $display("FAIL rst_unalloc got=%0h want=0", unalloc_wr); end
      total++; if (wa3 !== 4'd0 || wd3 !== 32'd0 || pc_wd !== 32'd0) begin bad++; $display("FAIL rst_port got=%0h/%0h/%0h want=0/0/0", wa3, wd3, pc_wd); end
      tick();
    end
    reset_n = 1;
    #2;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL rst_first_alu got=%0h want=1", alu_ready); end
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rst_first_mem got=%0h want=0", mem_ready); end
    tick();
    idle_inputs();
    #2;
    total++; if (we3 !== 1'b1 || wa3 !== 4'd4 || wd3 !== 32'h44) begin bad++; $display("FAIL rst_first_commit got=%0h/%0h/%0h want=1/4/44", we3, wa3, wd3); end
    tick();
  endtask

  task automatic test_single_alu;
    alloc_valid = 1; alloc_addr = 3;
    tick();
    alloc_valid = 0;
    alu_valid = 1; alu_addr = 3; alu_data = 32'hDEADBEEF;
    #2;
    total++; if (pending !== 16'h0008) begin bad++; $display("FAIL single_alloc got=%0h want=0008", pending); end
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0h want=1", alu_ready); end
    tick();
    alu_valid = 0;
    #2;
    total++; if (we3 !== 1'b1 || wa3 !== 4'd3 || wd3 !== 32'hDEADBEEF) begin bad++; $display("FAIL single_commit got=%0h/%0h/%0h want=1/3/deadbeef", we3, wa3, wd3); end
    total++; if (pc_we !== 1'b0 || unalloc_wr !== 1'b0) begin bad++; $display("FAIL single_flags got=%0h/%0h want=0/0", pc_we, unalloc_wr); end
    total++; if (pending[3] !== 1'b1) begin bad++; $display("FAIL single_pend_hold got=%0h want=1", pending[3]); end
    tick();
    #2;
    total++; if (we3 !== 1'b0 || pending !== 16'h0000) begin bad++; $display("FAIL single_after got=%0h/%0h want=0/0", we3, pending); end
  endtask

  task automatic test_contention;
    int exp_wa [4] = '{1, 2, 1, 2};
    bit exp_alu[4] = '{1, 0, 1, 0};
    do_reset();
    alu_valid = 1; alu_addr = 1; alu_data = 32'h11;
    mem_valid = 1; mem_addr = 2; mem_data = 32'h22;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin alu_valid = 0; mem_valid = 0; end
      #2;
      if (i < 4) begin
        total++; if (alu_ready !== exp_alu[i] || mem_ready !== !exp_alu[i]) begin bad++; $display("FAIL contention_grant%0d got=%0h/%0h want=%0h/%0h", i, alu_ready, mem_ready, exp_alu[i], !exp_alu[i]); end
      end
      if (i > 0) begin
        total++; if (we3 !== 1'b1 || wa3 !== 4'(exp_wa[i-1]) || wd3 !== (exp_wa[i-1] == 1 ? 32'h11 : 32'h22)) begin bad++; $display("FAIL contention_commit%0d got=%0h/%0h/%0h want=1/%0d", i, we3, wa3, wd3, exp_wa[i-1]); end
      end
      tick();
    end
    #2;
    total++; if (we3 !== 1'b0) begin bad++; $display("FAIL contention_idle got=%0h want=0", we3); end
  endtask

  task automatic test_pc_redirect;
    mem_valid = 1; mem_addr = 15; mem_data = 32'h0000_0100;
    #2;
    total++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin bad++; $display("FAIL pc_grant got=%0h/%0h want=1/0", mem_ready, alu_ready); end
    tick();
    mem_valid = 0;
    #2;
    total++; if (pc_we !== 1'b1 || pc_wd !== 32'h100) begin bad++; $display("FAIL pc_strobe got=%0h/%0h want=1/100", pc_we, pc_wd); end
    total++; if (we3 !== 1'b0 || wa3 !== 4'd2) begin bad++; $display("FAIL pc_rf_quiet got=%0h/%0h want=0/2", we3, wa3); end
    total++; if (unalloc_wr !== 1'b1) begin bad++; $display("FAIL pc_unalloc got=%0h want=1", unalloc_wr); end
    tick();
    #2;
    total++; if (pc_we !== 1'b0) begin bad++; $display("FAIL pc_oneshot got=%0h want=0", pc_we); end
  endtask

  task automatic test_hazard;
    do_reset();
    alloc_valid = 1; alloc_addr = 5; ra1 = 5; ra2 = 0;
    #2;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL haz_before got=%0h want=0", hazard); end
    tick();
    alloc_valid = 0;
    alu_valid = 1; alu_addr = 5; alu_data = 32'h55;
    #2;
    total++; if (hazard !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("FAIL haz_set got=%0h/%0h want=1/1", hazard, alu_ready); end
    tick();
    alu_valid = 0;
    alloc_valid = 1; alloc_addr = 5;
    #2;
    total++; if (we3 !== 1'b1 || wa3 !== 4'd5 || hazard !== 1'b1 || unalloc_wr !== 1'b0) begin bad++; $display("FAIL haz_commit got=%0h/%0h/%0h/%0h want=1/5/1/0", we3, wa3, hazard, unalloc_wr); end
    tick();
    alloc_valid = 0; ra1 = 0; ra2 = 5;
    alu_valid = 1; alu_addr = 5; alu_data = 32'h56;
    #2;
    total++; if (pending !== 16'h0020 || hazard !== 1'b1) begin bad++; $display("FAIL haz_same_edge got=%0h/%0h want=0020/1", pending, hazard); end
    tick();
    alu_valid = 0;
    #2;
    total++; if (we3 !== 1'b1 || hazard !== 1'b1) begin bad++; $display("FAIL haz_commit2 got=%0h/%0h want=1/1", we3, hazard); end
    tick();
    #2;
    total++; if (hazard !== 1'b0 || pending !== 16'h0000) begin bad++; $display("FAIL haz_clear got=%0h/%0h want=0/0", hazard, pending); end
  endtask

  task automatic test_unalloc;
    do_reset();
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
    tick();
    alu_valid = 0;
    #2;
    total++; if (we3 !== 1'b1 || wa3 !== 4'd7 || unalloc_wr !== 1'b1) begin bad++; $display("FAIL unalloc_pulse got=%0h/%0h/%0h want=1/7/1", we3, wa3, unalloc_wr); end
    tick();
    #2;
    total++; if (unalloc_wr !== 1'b0 || we3 !== 1'b0) begin bad++; $display("FAIL unalloc_end got=%0h/%0h want=0/0", unalloc_wr, we3); end
    alu_valid = 1; alu_addr = 7; alu_data = 32'h78;
    tick();
    alu_valid = 0;
    #2;
    total++; if (unalloc_wr !== 1'b1 || we3 !== 1'b1) begin bad++; $display("FAIL unalloc_pulse2 got=%0h/%0h want=1/1", unalloc_wr, we3); end
    reset_n = 0;
    #1;
    total++; if (we3 !== 1'b0 || unalloc_wr !== 1'b0 || wd3 !== 32'd0) begin bad++; $display("FAIL unalloc_async_rst got=%0h/%0h/%0h want=0/0/0", we3, unalloc_wr, wd3); end
    tick();
    reset_n = 1;
  endtask

  // Reference model: scoreboard as a plain bit vector, the commit stage as
  // "what the last accepted request was", and fairness as "who went last".
  task automatic test_random;
    logic [15:0] m_pend;
    bit          m_cv, m_cpc, m_last_alu, alu_hold, mem_hold, ga, gm;
    logic [3:0]  m_caddr, m_wa3, a;
    logic [31:0] m_wd3, m_pc_wd, d;
    do_reset();
    m_pend = 0; m_cv = 0; m_cpc = 0; m_last_alu = 0; m_caddr = 0;
    m_wa3 = 0; m_wd3 = 0; m_pc_wd = 0; alu_hold = 0; mem_hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (!alu_hold) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_addr = 4'($urandom_range(0, 15)); alu_data = $urandom;
      end
      if (!mem_hold) begin
        mem_valid = ($urandom_range(0, 99) < 60);
        mem_addr = 4'($urandom_range(0, 15)); mem_data = $urandom;
      end
      alloc_valid = ($urandom_range(0, 99) < 35);
      alloc_addr = 4'($urandom_range(0, 15));
      ra1 = 4'($urandom_range(0, 15));
      ra2 = 4'($urandom_range(0, 15));
      #2;
      ga = alu_valid && !(mem_valid && m_last_alu);
      gm = mem_valid && !ga;
      total++; if (alu_ready !== ga || mem_ready !== gm) begin bad++; $display("FAIL rnd_grant n=%0d got=%0h/%0h want=%0h/%0h", n, alu_ready, mem_ready, ga, gm); end
      total++; if (hazard !== (m_pend[ra1] | m_pend[ra2])) begin bad++; $display("FAIL rnd_hazard n=%0d got=%0h want=%0h", n, hazard, m_pend[ra1] | m_pend[ra2]); end
      total++; if (we3 !== (m_cv && !m_cpc) || pc_we !== (m_cv && m_cpc)) begin bad++; $display("FAIL rnd_strobe n=%0d got=%0h/%0h want=%0h/%0h", n, we3, pc_we, m_cv && !m_cpc, m_cv && m_cpc); end
      total++; if (wa3 !== m_wa3 || wd3 !== m_wd3 || pc_wd !== m_pc_wd) begin bad++; $display("FAIL rnd_data n=%0d got=%0h/%0h/%0h want=%0h/%0h/%0h", n, wa3, wd3, pc_wd, m_wa3, m_wd3, m_pc_wd); end
      total++; if (pending !== m_pend) begin bad++; $display("FAIL rnd_pending n=%0d got=%0h want=%0h", n, pending, m_pend); end
      total++; if (unalloc_wr !== (m_cv && !m_pend[m_caddr])) begin bad++; $display("FAIL rnd_unalloc n=%0d got=%0h want=%0h", n, unalloc_wr, m_cv && !m_pend[m_caddr]); end
      if (m_cv) m_pend[m_caddr] = 1'b0;
      if (alloc_valid) m_pend[alloc_addr] = 1'b1;
      if (ga || gm) begin
        a = ga ? alu_addr : mem_addr;
        d = ga ? alu_data : mem_data;
        m_cv = 1; m_caddr = a; m_cpc = (a == 4'd15);
        if (m_cpc) m_pc_wd = d;
        else begin m_wa3 = a; m_wd3 = d; end
        m_last_alu = ga;
      end else begin
        m_cv = 0;
      end
      alu_hold = alu_valid && !ga;
      mem_hold = mem_valid && !gm;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    @(negedge clk);
    test_reset();
    test_single_alu();
    test_contention();
    test_pc_redirect();
    test_hazard();
    test_unalloc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
